control_sequencer: RTL and testbench

Microstep sequencer and instruction decoder for the 8-bit CPU. It steps through a fixed five-step fetch/execute cycle and decodes the 4-bit opcode held in the instruction register. From these it produces the control word whose bits drive the `clock_enable` and output-enable inputs of the datapath registers (A, B, IR, MAR, PC, OUT) and the RAM. It sits directly upstream of every register block: each register's `clock_enable` is one bit of this block's output.

---
 rtl/cpu_ctrl_pkg.sv | 70 +++++++
 rtl/step_counter.sv | 38 +++
 rtl/control_sequencer.sv | 102 ++++++++++
 tb/tb_control_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared constants and types for the 8-bit CPU control path.
// Holds the control-word bit indices and masks, the opcode encodings, the
// microstep constants T0..T4, and the 16-bit control word type. The register,
// ALU and RAM blocks import this package to find their control bits.
package cpu_ctrl_pkg;

    localparam int unsigned STEPS    = 5;
    localparam int unsigned STEP_W   = 3;
    localparam int unsigned OPCODE_W = 4;
    localparam int unsigned CTRL_W   = 16;

    typedef logic [CTRL_W-1:0] ctrl_word_t;

    // Control-word bit positions
    localparam int unsigned HLT_B = 15;
    localparam int unsigned MI_B  = 14;
    localparam int unsigned RI_B  = 13;
    localparam int unsigned RO_B  = 12;
    localparam int unsigned IO_B  = 11;
    localparam int unsigned II_B  = 10;
    localparam int unsigned AI_B  = 9;
    localparam int unsigned AO_B  = 8;
    localparam int unsigned EO_B  = 7;
    localparam int unsigned SU_B  = 6;
    localparam int unsigned BI_B  = 5;
    localparam int unsigned OI_B  = 4;
    localparam int unsigned CE_B  = 3;
    localparam int unsigned CO_B  = 2;
    localparam int unsigned J_B   = 1;
    localparam int unsigned FI_B  = 0;

    // One-hot masks for building microcode words
    localparam ctrl_word_t C_HLT = ctrl_word_t'(1) << HLT_B;
    localparam ctrl_word_t C_MI  = ctrl_word_t'(1) << MI_B;
    localparam ctrl_word_t C_RI  = ctrl_word_t'(1) << RI_B;
    localparam ctrl_word_t C_RO  = ctrl_word_t'(1) << RO_B;
    localparam ctrl_word_t C_IO  = ctrl_word_t'(1) << IO_B;
    localparam ctrl_word_t C_II  = ctrl_word_t'(1) << II_B;
    localparam ctrl_word_t C_AI  = ctrl_word_t'(1) << AI_B;
    localparam ctrl_word_t C_AO  = ctrl_word_t'(1) << AO_B;
    localparam ctrl_word_t C_EO  = ctrl_word_t'(1) << EO_B;
    localparam ctrl_word_t C_SU  = ctrl_word_t'(1) << SU_B;
    localparam ctrl_word_t C_BI  = ctrl_word_t'(1) << BI_B;
    localparam ctrl_word_t C_OI  = ctrl_word_t'(1) << OI_B;
    localparam ctrl_word_t C_CE  = ctrl_word_t'(1) << CE_B;
    localparam ctrl_word_t C_CO  = ctrl_word_t'(1) << CO_B;
    localparam ctrl_word_t C_J   = ctrl_word_t'(1) << J_B;
    localparam ctrl_word_t C_FI  = ctrl_word_t'(1) << FI_B;

    // Opcodes (9..13 decode as NOP)
    localparam logic [OPCODE_W-1:0] OP_NOP = 4'd0;
    localparam logic [OPCODE_W-1:0] OP_LDA = 4'd1;
    localparam logic [OPCODE_W-1:0] OP_ADD = 4'd2;
    localparam logic [OPCODE_W-1:0] OP_SUB = 4'd3;
    localparam logic [OPCODE_W-1:0] OP_STA = 4'd4;
    localparam logic [OPCODE_W-1:0] OP_LDI = 4'd5;
    localparam logic [OPCODE_W-1:0] OP_JMP = 4'd6;
    localparam logic [OPCODE_W-1:0] OP_JC  = 4'd7;
    localparam logic [OPCODE_W-1:0] OP_JZ  = 4'd8;
    localparam logic [OPCODE_W-1:0] OP_OUT = 4'd14;
    localparam logic [OPCODE_W-1:0] OP_HLT = 4'd15;

    // Microsteps
    localparam logic [STEP_W-1:0] T0 = 3'd0;
    localparam logic [STEP_W-1:0] T1 = 3'd1;
    localparam logic [STEP_W-1:0] T2 = 3'd2;
    localparam logic [STEP_W-1:0] T3 = 3'd3;
    localparam logic [STEP_W-1:0] T4 = 3'd4;

endpackage

// File: rtl/step_counter.sv
// Mod-STEPS microstep counter.
// Ports: clock (rising edge), clear (sync, active high, forces T0),
//        enable (advance one step per clock), step (current microstep).
module step_counter
    import cpu_ctrl_pkg::*;
(
    input  logic              clock,
    input  logic              clear,
    input  logic              enable,
    output logic [STEP_W-1:0] step
);

    logic [STEP_W-1:0] step_q;
    logic [STEP_W-1:0] step_d;

    // Wrap from the last step back to T0
    always_comb begin
        step_d = step_q;
        if (enable) begin
            if (step_q == STEP_W'(STEPS - 1)) begin
                step_d = T0;
            end else begin
                step_d = step_q + STEP_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            step_q <= T0;
        end else begin
            step_q <= step_d;
        end
    end

    assign step = step_q;

endmodule

// File: rtl/control_sequencer.sv
// Microstep sequencer and instruction decoder for the 8-bit CPU.
// Ports: clock, clear (sync, active high), run (1 = advance), opcode (IR upper
//        nibble, valid T2..T4), carry_flag/zero_flag (registered flags),
//        step (current microstep), halted (set after HLT), ctrl (control word,
//        combinational from step/opcode/flags/run/halted/clear).
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic                clock,
    input  logic                clear,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                carry_flag,
    input  logic                zero_flag,
    output logic [STEP_W-1:0]   step,
    output logic                halted,
    output logic [CTRL_W-1:0]   ctrl
);

    logic              halted_q;
    logic              halted_d;
    logic              halt_now;
    logic              count_en;
    logic [STEP_W-1:0] step_w;
    ctrl_word_t        ucode;

    // HLT completes on the edge that ends T2; the counter must not advance on
    // that same edge so step freezes at T2.
    assign halt_now = run && !halted_q && (step_w == T2) && (opcode == OP_HLT);
    assign count_en = run && !halted_q && !halt_now;
    assign halted_d = halted_q || halt_now;

    always_ff @(posedge clock) begin
        if (clear) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    step_counter u_step_counter (
        .clock  (clock),
        .clear  (clear),
        .enable (count_en),
        .step   (step_w)
    );

    // Microcode: fetch is common, execute decodes opcode at T2..T4
    always_comb begin
        ucode = ctrl_word_t'(0);
        if (step_w == T0) begin
            ucode = C_CO | C_MI;
        end else if (step_w == T1) begin
            ucode = C_RO | C_II | C_CE;
        end else begin
            case (opcode)
                OP_LDA: begin
                    if (step_w == T2) ucode = C_IO | C_MI;
                    else if (step_w == T3) ucode = C_RO | C_AI;
                end
                OP_ADD: begin
                    if (step_w == T2) ucode = C_IO | C_MI;
                    else if (step_w == T3) ucode = C_RO | C_BI;
                    else if (step_w == T4) ucode = C_EO | C_AI | C_FI;
                end
                OP_SUB: begin
                    if (step_w == T2) ucode = C_IO | C_MI;
                    else if (step_w == T3) ucode = C_RO | C_BI;
                    else if (step_w == T4) ucode = C_EO | C_AI | C_SU | C_FI;
                end
                OP_STA: begin
                    if (step_w == T2) ucode = C_IO | C_MI;
                    else if (step_w == T3) ucode = C_AO | C_RI;
                end
                OP_LDI: if (step_w == T2) ucode = C_IO | C_AI;
                OP_JMP: if (step_w == T2) ucode = C_IO | C_J;
                OP_JC:  if (step_w == T2 && carry_flag) ucode = C_IO | C_J;
                OP_JZ:  if (step_w == T2 && zero_flag) ucode = C_IO | C_J;
                OP_OUT: if (step_w == T2) ucode = C_AO | C_OI;
                OP_HLT: if (step_w == T2) ucode = C_HLT;
                default: ucode = ctrl_word_t'(0);
            endcase
        end
    end

    // Gating priority: clear, then halt, then pause
    always_comb begin
        if (clear) begin
            ctrl = ctrl_word_t'(0);
        end else if (halted_q) begin
            ctrl = C_HLT;
        end else if (!run) begin
            ctrl = ctrl_word_t'(0);
        end else begin
            ctrl = ucode;
        end
    end

    assign step   = step_w;
    assign halted = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios with literal
// expectations, then randomized stimulus checked every cycle against a
// table-driven behavioural model.
module tb_control_sequencer;

    logic        clock;
    logic        clear;
    logic        run;
    logic [3:0]  opcode;
    logic        carry_flag;
    logic        zero_flag;
    logic [2:0]  step;
    logic        halted;
    logic [15:0] ctrl;

    int n_cmp  = 0;
    int n_fail = 0;
    bit model_en = 0;

    control_sequencer dut (
        .clock      (clock),
        .clear      (clear),
        .run        (run),
        .opcode     (opcode),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .step       (step),
        .halted     (halted),
        .ctrl       (ctrl)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Bit masks written out from the bit-order list HLT..FI
    localparam logic [15:0] M_HLT = 16'h8000, M_MI = 16'h4000, M_RI = 16'h2000,
                            M_RO  = 16'h1000, M_IO = 16'h0800, M_II = 16'h0400,
                            M_AI  = 16'h0200, M_AO = 16'h0100, M_EO = 16'h0080,
                            M_SU  = 16'h0040, M_BI = 16'h0020, M_OI = 16'h0010,
                            M_CE  = 16'h0008, M_CO = 16'h0004, M_J  = 16'h0002,
                            M_FI  = 16'h0001;

    // Reference microcode table: [opcode][execute step 0..2]
    logic [15:0] exec_tbl [16][3];
    logic [15:0] fetch_tbl [2];

    initial begin
        for (int o = 0; o < 16; o++)
            for (int k = 0; k < 3; k++) exec_tbl[o][k] = 16'h0000;
        fetch_tbl[0] = M_CO | M_MI;
        fetch_tbl[1] = M_RO | M_II | M_CE;
        exec_tbl[1]  = '{M_IO | M_MI, M_RO | M_AI, 16'h0000};
        exec_tbl[2]  = '{M_IO | M_MI, M_RO | M_BI, M_EO | M_AI | M_FI};
        exec_tbl[3]  = '{M_IO | M_MI, M_RO | M_BI, M_EO | M_AI | M_SU | M_FI};
        exec_tbl[4]  = '{M_IO | M_MI, M_AO | M_RI, 16'h0000};
        exec_tbl[5]  = '{M_IO | M_AI, 16'h0000, 16'h0000};
        exec_tbl[6]  = '{M_IO | M_J, 16'h0000, 16'h0000};
        exec_tbl[7]  = '{M_IO | M_J, 16'h0000, 16'h0000};
        exec_tbl[8]  = '{M_IO | M_J, 16'h0000, 16'h0000};
        exec_tbl[14] = '{M_AO | M_OI, 16'h0000, 16'h0000};
        exec_tbl[15] = '{M_HLT, 16'h0000, 16'h0000};
    end

    // Behavioural state: instruction phase 0..4 and halt flag
    int m_step = 0;
    bit m_halt = 0;

    always @(posedge clock) begin
        if (clear) begin
            m_step = 0;
            m_halt = 0;
        end else if (!m_halt && run) begin
            if (m_step == 2 && opcode == 4'd15) m_halt = 1;
            else m_step = (m_step + 1) % 5;
        end
    end

    function automatic logic [15:0] model_ctrl();
        logic [15:0] w;
        if (clear) return 16'h0000;
        if (m_halt) return M_HLT;
        if (!run) return 16'h0000;
        if (m_step < 2) return fetch_tbl[m_step];
        w = exec_tbl[opcode][m_step - 2];
        if (opcode == 4'd7 && !carry_flag) w = 16'h0000;
        if (opcode == 4'd8 && !zero_flag) w = 16'h0000;
        return w;
    endfunction

    function automatic void chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endfunction

    // Per-cycle comparison against the model
    always @(negedge clock) begin
        if (model_en) begin
            chk("model.step", 16'(step), 16'(m_step));
            chk("model.halted", 16'(halted), 16'(m_halt));
            chk("model.ctrl", ctrl, model_ctrl());
        end
    end

    // Apply inputs just after an edge, then wait to the sampling point
    task automatic cyc(input logic clr, input logic rn, input logic [3:0] op,
                       input logic cf, input logic zf);
        @(posedge clock);
        #1;
        clear = clr; run = rn; opcode = op; carry_flag = cf; zero_flag = zf;
        @(negedge clock);
    endtask

    task automatic instr(input logic [3:0] op, input logic cf, input logic zf,
                         input int at, input logic [15:0] exp, input string name);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, op, cf, zf);
            chk({name, ".step"}, 16'(step), 16'(i));
            if (i == at) chk(name, ctrl, exp);
        end
    endtask

    initial begin
        clear = 1'b1; run = 1'b0; opcode = 4'd0; carry_flag = 1'b0; zero_flag = 1'b0;
        cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        model_en = 1;
        cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("reset.ctrl", ctrl, 16'h0000);
        chk("reset.step", 16'(step), 16'h0000);
        chk("reset.halted", 16'(halted), 16'h0000);

        // LDA full sequence
        instr(4'd1, 1'b0, 1'b0, 0, 16'h4004, "lda.t0");
        // Re-run LDA with a literal per step
        begin
            logic [15:0] lda_exp [5];
            lda_exp = '{16'h4004, 16'h1408, 16'h4800, 16'h1200, 16'h0000};
            for (int i = 0; i < 5; i++) begin
                cyc(1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
                chk("lda.ctrl", ctrl, lda_exp[i]);
            end
        end
        instr(4'd3, 1'b0, 1'b0, 4, 16'h02C1, "sub.t4");
        instr(4'd2, 1'b0, 1'b0, 4, 16'h0281, "add.t4");
        instr(4'd7, 1'b0, 1'b1, 2, 16'h0000, "jc.c0");
        instr(4'd7, 1'b1, 1'b0, 2, 16'h0802, "jc.c1");
        instr(4'd8, 1'b1, 1'b0, 2, 16'h0000, "jz.z0");
        instr(4'd8, 1'b0, 1'b1, 2, 16'h0802, "jz.z1");
        instr(4'd14, 1'b0, 1'b0, 2, 16'h0110, "out.t2");

        // Pause at T3 of ADD
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 4'd2, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 4'd2, 1'b0, 1'b0);
            chk("pause.step", 16'(step), 16'd3);
            chk("pause.ctrl", ctrl, 16'h0000);
        end
        cyc(1'b0, 1'b1, 4'd2, 1'b0, 1'b0);
        chk("resume.ctrl", ctrl, 16'h1020);
        cyc(1'b0, 1'b1, 4'd2, 1'b0, 1'b0);
        chk("resume.t4", ctrl, 16'h0281);

        // Clear in the middle of LDA
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 4'd1, 1'b0, 1'b0);
        chk("midclr.ctrl", ctrl, 16'h0000);
        cyc(1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
        chk("midclr.step", 16'(step), 16'd0);
        chk("midclr.t0", ctrl, 16'h4004);

        // HLT with run dropped at T2, then halt proper
        cyc(1'b0, 1'b1, 4'd15, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 4'd15, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 4'd15, 1'b0, 1'b0);
        chk("hltpause.halted", 16'(halted), 16'd0);
        chk("hltpause.step", 16'(step), 16'd2);
        cyc(1'b0, 1'b1, 4'd15, 1'b0, 1'b0);
        chk("hlt.t2", ctrl, 16'h8000);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'(i % 2), 4'd15, 1'b0, 1'b0);
            chk("halt.halted", 16'(halted), 16'd1);
            chk("halt.step", 16'(step), 16'd2);
            chk("halt.ctrl", ctrl, 16'h8000);
        end
        cyc(1'b1, 1'b1, 4'd15, 1'b0, 1'b0);
        chk("haltclr.ctrl", ctrl, 16'h0000);
        cyc(1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
        chk("haltclr.halted", 16'(halted), 16'd0);
        chk("haltclr.step", 16'(step), 16'd0);
        chk("haltclr.t0", ctrl, 16'h4004);

        // Randomized traffic, checked by the per-cycle model
        for (int i = 0; i < 3000; i++) begin
            cyc(1'(($urandom % 50) == 0), 1'(($urandom % 8) != 0), 4'($urandom),
                1'($urandom), 1'($urandom));
        end

        model_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
